// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift left/right, hold.
// Serial fill comes from data_l (low end) and data_h (high end).
module univ_shift_reg #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic [1:0]    ctrl,
    input  logic [DW-1:0] data,
    input  logic          data_l,
    input  logic          data_h,
    output logic [DW-1:0] q
);

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    mode_t mode;

    assign mode = mode_t'(ctrl);

    // Unknown ctrl values fall into the hold branch.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            q <= '0;
        end else begin
            case (mode)
                MODE_LOAD: q <= data;
                MODE_SHR:  q <= {data_h, q[DW-1:1]};
                MODE_SHL:  q <= {q[DW-2:0], data_l};
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (DW=4).
// Inputs change just after each rising edge; q is checked 1 time unit later.
module tb_univ_shift_reg;

    localparam int DW = 4;

    logic          clk;
    logic          sync_rst;
    logic [1:0]    ctrl;
    logic [DW-1:0] data;
    logic          data_l;
    logic          data_h;
    logic [DW-1:0] q;

    int vectors;
    int errors;

    univ_shift_reg #(.DW(DW)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .ctrl     (ctrl),
        .data     (data),
        .data_l   (data_l),
        .data_h   (data_h),
        .q        (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic [1:0] c,
                        input logic [DW-1:0] d, input logic dl,
                        input logic dh);
        sync_rst = rst;
        ctrl     = c;
        data     = d;
        data_l   = dl;
        data_h   = dh;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 2'b00, 4'hF, 1'b1, 1'b1);
        vectors++;
        if (q !== 4'h0) begin
            errors++;
            $display("FAIL reset_beats_load: got %h want %h", q, 4'h0);
        end
    endtask

    task automatic test_load_hold;
        step(1'b0, 2'b00, 4'hA, 1'b0, 1'b0);
        vectors++;
        if (q !== 4'hA) begin
            errors++;
            $display("FAIL load_a: got %h want %h", q, 4'hA);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 2'b11, 4'($urandom), 1'($urandom), 1'($urandom));
            vectors++;
            if (q !== 4'hA) begin
                errors++;
                $display("FAIL hold_%0d: got %h want %h", i, q, 4'hA);
            end
        end
    endtask

    task automatic test_left_shift;
        logic [DW-1:0] exp_q [8];
        logic          dl_v  [8];
        logic [1:0]    c_v   [8];
        // shl 1, shl 0, hold x2, shl 1, shl 1, hold x2 starting at 4'hA
        c_v   = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11};
        dl_v  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_q = '{4'h5, 4'hA, 4'hA, 4'hA, 4'h5, 4'hB, 4'hB, 4'hB};
        step(1'b0, 2'b00, 4'hA, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, c_v[i], 4'h0, dl_v[i], 1'(i % 2 == 0));
            vectors++;
            if (q !== exp_q[i]) begin
                errors++;
                $display("FAIL shl_step_%0d: got %h want %h",
                         i, q, exp_q[i]);
            end
        end
    endtask

    task automatic test_right_shift;
        logic [DW-1:0] model;
        logic          dh_v [12];
        logic [1:0]    c_v;
        dh_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        step(1'b0, 2'b00, 4'h6, 1'b0, 1'b0);
        model = 4'h6;
        for (int i = 0; i < 12; i++) begin
            c_v = ((i % 4) < 2) ? 2'b01 : 2'b11;
            step(1'b0, c_v, 4'($urandom), 1'(i % 2), dh_v[i]);
            if (c_v == 2'b01) model = {dh_v[i], model[DW-1:1]};
            vectors++;
            if (q !== model) begin
                errors++;
                $display("FAIL shr_step_%0d: got %h want %h", i, q, model);
            end
            if (i == 1) begin
                vectors++;
                if (q !== 4'hD) begin
                    errors++;
                    $display("FAIL shr_fixed_d: got %h want %h", q, 4'hD);
                end
            end
        end
    endtask

    task automatic test_fill_flush;
        logic [DW-1:0] fill  [4];
        logic [DW-1:0] flush [4];
        fill  = '{4'h1, 4'h3, 4'h7, 4'hF};
        flush = '{4'h7, 4'h3, 4'h1, 4'h0};
        step(1'b0, 2'b00, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b10, 4'h0, 1'b1, 1'b0);
            vectors++;
            if (q !== fill[i]) begin
                errors++;
                $display("FAIL fill_%0d: got %h want %h", i, q, fill[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b01, 4'hF, 1'b1, 1'b0);
            vectors++;
            if (q !== flush[i]) begin
                errors++;
                $display("FAIL flush_%0d: got %h want %h", i, q, flush[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        step(1'b0, 2'b00, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'b10, 4'h0, 1'b1, 1'b0);
        vectors++;
        if (q !== 4'h7) begin
            errors++;
            $display("FAIL pre_reset: got %h want %h", q, 4'h7);
        end
        step(1'b1, 2'b10, 4'hF, 1'b1, 1'b1);
        vectors++;
        if (q !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h want %h", q, 4'h0);
        end
        step(1'b0, 2'b10, 4'hF, 1'b1, 1'b1);
        vectors++;
        if (q !== 4'h1) begin
            errors++;
            $display("FAIL resume_shl: got %h want %h", q, 4'h1);
        end
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        sync_rst = 1'b1;
        ctrl     = 2'b00;
        data     = '0;
        data_l   = 1'b0;
        data_h   = 1'b0;
        test_reset();
        test_load_hold();
        test_left_shift();
        test_right_shift();
        test_fill_flush();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
